// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and helpers for the multiplexed seven-segment scanner
//   NUM_DIGITS, SEG_W, IDX_W : display geometry
//   IDX_S1 .. IDX_H10        : scan index of each digit (seconds units first)
//   blank_code()             : all-segments-off pattern for the selected polarity
//   com_select()             : active-low one-cold digit enable for a scan index
package disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;
    localparam int IDX_W      = 3;

    localparam logic [IDX_W-1:0] IDX_S1  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_S10 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_M1  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_M10 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_H1  = 3'd4;
    localparam logic [IDX_W-1:0] IDX_H10 = 3'd5;

    function automatic logic [SEG_W-1:0] blank_code(input bit active_low);
        return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    endfunction

    // Index values 6 and 7 never occur; they map to "no digit enabled".
    function automatic logic [NUM_DIGITS-1:0] com_select(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] sel;
        sel = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i] = 1'b0;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// rtl/scan_tick.sv - slot prescaler, digit scan index and end-of-frame tick
//   clk, rst   : clock, synchronous active-low reset
//   presc      : position inside the current digit slot, 0..SCAN_DIV-1
//   index      : digit currently being driven, 0..NUM_DIGITS-1
//   frame_tick : high in the last cycle of the last slot of a frame
module scan_tick
    import disp_pkg::*;
#(
    parameter  int SCAN_DIV = 10000,
    localparam int PW       = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PW-1:0]    presc,
    output logic [IDX_W-1:0] index,
    output logic             frame_tick
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic slot_end;

    // Both ticks are pure decodes of the counters so they carry no input path.
    assign slot_end   = (presc == PRESC_LAST);
    assign frame_tick = slot_end && (index == IDX_H10);

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            index <= IDX_S1;
        end else if (slot_end) begin
            presc <= '0;
            index <= (index == IDX_H10) ? IDX_S1 : index + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit multiplexed seven-segment driver with ghost blanking and blink
//   clk, rst                     : clock, synchronous active-low reset
//   s1, s10, m1, m10, h1, h10    : segment codes for digits 0..5
//   blink_en                     : per-digit blink enable, sampled live
//   seg                          : shared segment bus
//   com                          : active-low digit enables, at most one low
//   frame_tick                   : one-cycle pulse at the end of each frame
module seg_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int GHOST          = 2,
    parameter int BLINK_DIV      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      s1,
    input  logic [SEG_W-1:0]      s10,
    input  logic [SEG_W-1:0]      m1,
    input  logic [SEG_W-1:0]      m10,
    input  logic [SEG_W-1:0]      h1,
    input  logic [SEG_W-1:0]      h10,
    input  logic [NUM_DIGITS-1:0] blink_en,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] com,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    // A single-frame blink period still needs a one-bit counter to exist.
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SEG_W-1:0] BLANK      = blank_code(SEG_ACTIVE_LOW);
    localparam logic [PW-1:0]    GHOST_END  = PW'(GHOST);
    localparam logic [FW-1:0]    FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0]    presc;
    logic [IDX_W-1:0] index;
    logic             frame_end;

    logic [FW-1:0]    frame_cnt;
    logic             blink_phase;
    logic [SEG_W-1:0] shadow [NUM_DIGITS];

    logic             ghost;
    logic [SEG_W-1:0] cur_seg;
    logic             cur_blink;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk        (clk),
        .rst        (rst),
        .presc      (presc),
        .index      (index),
        .frame_tick (frame_end)
    );

    // Frame counter and blink phase; the phase flips once every BLINK_DIV frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Digit data is captured only at the frame boundary so a frame never
    // mixes old and new values. Reset loads blank, so the first frame is dark.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= BLANK;
            end
        end else if (frame_end) begin
            shadow[IDX_S1]  <= s1;
            shadow[IDX_S10] <= s10;
            shadow[IDX_M1]  <= m1;
            shadow[IDX_M10] <= m10;
            shadow[IDX_H1]  <= h1;
            shadow[IDX_H10] <= h10;
        end
    end

    // Blink enable is deliberately not shadowed: it takes effect immediately.
    always_comb begin
        cur_seg   = BLANK;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_seg   = shadow[i];
                cur_blink = blink_en[i];
            end
        end
    end

    // Ghost window: every digit is off at the start of a slot so the previous
    // digit's pattern cannot bleed into the newly enabled common.
    assign ghost = (presc < GHOST_END);

    always_comb begin
        seg = cur_seg;
        com = com_select(index);
        if (ghost) begin
            seg = BLANK;
            com = {NUM_DIGITS{1'b1}};
        end else if (blink_phase && cur_blink) begin
            seg = BLANK;
        end
    end

    assign frame_tick = frame_end;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan with SCAN_DIV=4, GHOST=1, BLINK_DIV=2
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] s1, s10, m1, m10, h1, h10;
    logic [5:0] blink_en;
    logic [6:0] seg;
    logic [5:0] com;
    logic       frame_tick;

    seg_scan #(
        .SCAN_DIV       (4),
        .GHOST          (1),
        .BLINK_DIV      (2),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s1         (s1),
        .s10        (s10),
        .m1         (m1),
        .m10        (m10),
        .h1         (h1),
        .h10        (h10),
        .blink_en   (blink_en),
        .seg        (seg),
        .com        (com),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         gc;
        logic [5:0] com;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   gc     = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rel    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        gc++;
    endtask

    // Expected output for one frame (or its first ncyc cycles), written out
    // from the slot layout: 1 dark cycle then 3 cycles of one low common.
    task automatic push_frame(input int base, input logic [5:0][6:0] d,
                              input logic [5:0] blank, input int ncyc);
        exp_t       e;
        int         slot;
        int         ph;
        logic [5:0] one;
        for (int k = 0; k < ncyc; k++) begin
            slot  = k / 4;
            ph    = k % 4;
            one   = 6'b000001 << slot;
            e.gc  = base + k;
            if (ph == 0) begin
                e.com = 6'b111111;
                e.seg = 7'h00;
            end else begin
                e.com = ~one;
                e.seg = blank[slot] ? 7'h00 : d[slot];
            end
            e.tick = (slot == 5) && (ph == 3);
            q.push_back(e);
        end
    endtask

    task automatic push_reset(input int at);
        exp_t e;
        e.gc   = at;
        e.com  = 6'b111111;
        e.seg  = 7'h00;
        e.tick = 1'b0;
        q.push_back(e);
    endtask

    // Holds reset for n edges; the cycle after the last edge is the first
    // released cycle and is covered by the following frame expectations.
    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 1; i < n; i++) begin
            push_reset(gc + i);
        end
        for (int i = 0; i < n; i++) begin
            tick();
        end
        rst = 1'b1;
        rel = gc;
    endtask

    // Monitor: every cycle, check the ghost invariants, then retire any
    // expectation due for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (gc >= 1) begin
            n_cmp++;
            if ($countones(~com) > 1) begin
                n_fail++;
                $display("FAIL onehot_com cyc=%0d com=%b required at most one low", gc, com);
            end
            n_cmp++;
            if (com == 6'b111111 && seg !== 7'h00) begin
                n_fail++;
                $display("FAIL dark_seg cyc=%0d seg=%h required 00 while com=111111", gc, seg);
            end
            while (q.size() > 0 && q[0].gc <= gc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.gc < gc) begin
                    n_fail++;
                    $display("FAIL missed_expect cyc=%0d expected at cyc=%0d", gc, e.gc);
                end else if (com !== e.com || seg !== e.seg || frame_tick !== e.tick) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d rel=%0d com=%b seg=%h tick=%b required com=%b seg=%h tick=%b",
                             gc, gc - rel, com, seg, frame_tick, e.com, e.seg, e.tick);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        s1       = 7'h06;
        s10      = 7'h00;
        m1       = 7'h00;
        m10      = 7'h00;
        h1       = 7'h00;
        h10      = 7'h5B;
        blink_en = 6'b000000;

        // Power-up reset, snapshot and frame_tick cadence.
        do_reset(3);
        push_frame(rel +   0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}, 6'b000000, 24);
        push_frame(rel +  24, {7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06}, 6'b000000, 24);
        push_frame(rel +  48, {7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 6'b000000, 24);
        push_frame(rel +  72, {7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 6'b000000, 24);
        push_frame(rel +  96, {7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 6'b000000, 15);
        for (int k = 1; k <= 110; k++) begin
            tick();
            if (gc - rel == 30) begin
                s1 = 7'h3F;
            end
        end

        // Reset lands at index 3, prescaler 2; new data and blink set up meanwhile.
        s1       = 7'h7F;
        s10      = 7'h7F;
        m1       = 7'h7F;
        m10      = 7'h7F;
        h1       = 7'h7F;
        h10      = 7'h7F;
        blink_en = 6'b000001;
        do_reset(3);

        push_frame(rel +   0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}, 6'b000000, 24);
        push_frame(rel +  24, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 6'b000000, 24);
        push_frame(rel +  48, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 6'b000001, 24);
        push_frame(rel +  72, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 6'b000001, 24);
        push_frame(rel +  96, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 6'b000000, 24);
        push_frame(rel + 120, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 6'b000000, 24);
        for (int k = 1; k <= 145; k++) begin
            tick();
        end

        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
